prefetch_control: RTL and testbench

//   Sequences instruction prefetch into prefetch_fifo. Tracks the current linear fetch address and CS limit.

---
 rtl/prefetch_control_if.sv | 19 +
 rtl/prefetch_control.sv | 112 +++++++++++
 tb/tb_prefetch_control.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/prefetch_control_if.sv
// Fetch request/response bus between the prefetch sequencer and the icache read port.
interface prefetch_control_if;
   logic        fetch_req;
   logic [31:0] fetch_address;
   logic [4:0]  fetch_length;
   logic        fetch_ack;
   logic        fetch_done;
   logic        fetch_page_fault;

   modport master (
      output fetch_req, fetch_address, fetch_length,
      input  fetch_ack, fetch_done, fetch_page_fault
   );

   modport slave (
      input  fetch_req, fetch_address, fetch_length,
      output fetch_ack, fetch_done, fetch_page_fault
   );
endinterface

// File: rtl/prefetch_control.sv
// Prefetch sequencer: issues one line-bounded icache read at a time while the FIFO has room,
// and turns limit overrun / page fault into single-cycle FIFO fault-entry pulses.
module prefetch_control #(
   parameter int unsigned FIFO_THRESHOLD = 12,
   parameter int unsigned LINE_BYTES     = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_pr_reset,
   input  logic [31:0]               i_prefetch_start_address,
   input  logic [31:0]               i_prefetch_cs_limit,
   input  logic                      i_prefetch_enable,
   input  logic [4:0]                i_prefetchfifo_used,
   prefetch_control_if.master        fetch_if,
   output logic                      o_prefetchfifo_signal_limit_do,
   output logic                      o_prefetchfifo_signal_pf_do,
   output logic                      o_busy
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LEN_W  = 5;
   localparam int unsigned OFS_W  = $clog2(LINE_BYTES);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_STOPPED
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   r_limit;
   logic [LEN_W-1:0]    r_len;
   logic                r_limit_do;
   logic                r_pf_do;

   logic                w_over;
   logic [ADDR_W:0]     w_room;
   logic [ADDR_W:0]     w_rem;
   logic [LEN_W-1:0]    w_len;
   logic                w_below;
   logic                w_req;

   // Window length: stop at the line boundary or the inclusive limit, whichever is first.
   assign w_over  = (r_addr > r_limit);
   assign w_room  = (ADDR_W+1)'(LINE_BYTES) - (ADDR_W+1)'(r_addr[OFS_W-1:0]);
   assign w_rem   = (ADDR_W+1)'(r_limit) - (ADDR_W+1)'(r_addr) + (ADDR_W+1)'(1);
   assign w_len   = w_over ? '0 : ((w_room < w_rem) ? LEN_W'(w_room) : LEN_W'(w_rem));
   assign w_below = (i_prefetchfifo_used < LEN_W'(FIFO_THRESHOLD));
   assign w_req   = (r_state == S_REQ) & i_prefetch_enable & ~i_pr_reset & w_below & ~w_over;

   assign fetch_if.fetch_req     = w_req;
   assign fetch_if.fetch_address = r_addr;
   assign fetch_if.fetch_length  = (r_state == S_IDLE) ? '0 : w_len;

   assign o_prefetchfifo_signal_limit_do = r_limit_do;
   assign o_prefetchfifo_signal_pf_do    = r_pf_do;
   assign o_busy                         = (r_state == S_WAIT) || (r_state == S_DRAIN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_limit    <= '0;
         r_len      <= '0;
         r_limit_do <= 1'b0;
         r_pf_do    <= 1'b0;
      end else begin
         r_limit_do <= 1'b0;
         r_pf_do    <= 1'b0;
         if (i_pr_reset) begin
            // Restart wins over everything; an outstanding read must still be drained.
            r_addr  <= i_prefetch_start_address;
            r_limit <= i_prefetch_cs_limit;
            case (r_state)
               S_WAIT, S_DRAIN: r_state <= fetch_if.fetch_done ? S_REQ : S_DRAIN;
               default:         r_state <= S_REQ;
            endcase
         end else begin
            case (r_state)
               S_REQ: begin
                  if (w_req && fetch_if.fetch_ack) begin
                     r_len   <= w_len;
                     r_state <= S_WAIT;
                  end else if (w_over && !i_prefetchfifo_used[4] && i_prefetch_enable) begin
                     r_limit_do <= 1'b1;
                     r_state    <= S_STOPPED;
                  end
               end
               S_WAIT: begin
                  if (fetch_if.fetch_done) begin
                     if (fetch_if.fetch_page_fault) begin
                        r_pf_do <= 1'b1;
                        r_state <= S_STOPPED;
                     end else begin
                        r_addr  <= r_addr + ADDR_W'(r_len);
                        r_state <= S_REQ;
                     end
                  end
               end
               S_DRAIN: begin
                  if (fetch_if.fetch_done) begin
                     r_state <= S_REQ;
                  end
               end
               default: begin
                  r_state <= r_state;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prefetch_control.sv
// Directed bench for prefetch_control: restart, line/limit windows, faults, flush and wrap.
module tb_prefetch_control;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        pr_reset;
   logic [31:0] start_addr;
   logic [31:0] cs_limit;
   logic        enable;
   logic [4:0]  used;
   logic        limit_do;
   logic        pf_do;
   logic        busy;
   int          n_tests = 0;
   int          n_fail  = 0;

   prefetch_control_if fif();

   prefetch_control dut (
      .clk                            (clk),
      .rst_n                          (rst_n),
      .i_pr_reset                     (pr_reset),
      .i_prefetch_start_address       (start_addr),
      .i_prefetch_cs_limit            (cs_limit),
      .i_prefetch_enable              (enable),
      .i_prefetchfifo_used            (used),
      .fetch_if                       (fif),
      .o_prefetchfifo_signal_limit_do (limit_do),
      .o_prefetchfifo_signal_pf_do    (pf_do),
      .o_busy                         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept();
      fif.fetch_ack = 1'b1;
      tick();
      fif.fetch_ack = 1'b0;
   endtask

   task automatic complete(input logic pf);
      fif.fetch_done       = 1'b1;
      fif.fetch_page_fault = pf;
      tick();
      fif.fetch_done       = 1'b0;
      fif.fetch_page_fault = 1'b0;
   endtask

   task automatic restart(input logic [31:0] s, input logic [31:0] l);
      start_addr = s;
      cs_limit   = l;
      pr_reset   = 1'b1;
      tick();
      pr_reset   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pr_reset = 1'b0; enable = 1'b1; used = 5'd0;
      start_addr = 32'h0; cs_limit = 32'h0;
      fif.fetch_ack = 1'b0; fif.fetch_done = 1'b0; fif.fetch_page_fault = 1'b0;
      tick(); tick(); #1;
      n_tests++; if (fif.fetch_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %0b want 0", fif.fetch_req); end
      n_tests++; if (fif.fetch_address !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0", fif.fetch_address); end
      n_tests++; if (fif.fetch_length !== 5'd0) begin n_fail++; $display("FAIL rst_len got %0d want 0", fif.fetch_length); end
      n_tests++; if ({limit_do, pf_do, busy} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b want 000", {limit_do, pf_do, busy}); end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(); #1;
         n_tests++; if (fif.fetch_req !== 1'b0) begin n_fail++; $display("FAIL idle_req cyc %0d got %0b want 0", i, fif.fetch_req); end
      end
   endtask

   task automatic test_sequential();
      start_addr = 32'h1000; cs_limit = 32'h0000_FFFF; pr_reset = 1'b1; #1;
      n_tests++; if (fif.fetch_req !== 1'b0) begin n_fail++; $display("FAIL t1_req_in_prreset got %0b want 0", fif.fetch_req); end
      tick(); pr_reset = 1'b0; #1;
      n_tests++; if ({fif.fetch_req, fif.fetch_address, fif.fetch_length} !== {1'b1, 32'h1000, 5'd16})
         begin n_fail++; $display("FAIL t1_req0 got %b %h %0d want 1 00001000 16", fif.fetch_req, fif.fetch_address, fif.fetch_length); end
      accept(); #1;
      n_tests++; if ({busy, fif.fetch_req} !== 2'b10) begin n_fail++; $display("FAIL t1_wait got busy/req %b want 10", {busy, fif.fetch_req}); end
      tick();
      complete(1'b0); #1;
      n_tests++; if ({fif.fetch_req, fif.fetch_address, fif.fetch_length} !== {1'b1, 32'h1010, 5'd16})
         begin n_fail++; $display("FAIL t1_req1 got %b %h %0d want 1 00001010 16", fif.fetch_req, fif.fetch_address, fif.fetch_length); end
      accept(); tick();
      complete(1'b0); #1;
      n_tests++; if (fif.fetch_address !== 32'h1020) begin n_fail++; $display("FAIL t1_req2 got %h want 00001020", fif.fetch_address); end
   endtask

   task automatic test_limit();
      restart(32'h100A, 32'h100F); #1;
      n_tests++; if ({fif.fetch_req, fif.fetch_address, fif.fetch_length} !== {1'b1, 32'h100A, 5'd6})
         begin n_fail++; $display("FAIL t2_req got %b %h %0d want 1 0000100a 6", fif.fetch_req, fif.fetch_address, fif.fetch_length); end
      accept(); complete(1'b0); #1;
      n_tests++; if ({fif.fetch_req, fif.fetch_length, limit_do} !== {1'b0, 5'd0, 1'b0})
         begin n_fail++; $display("FAIL t2_over got req %b len %0d lim %b want 0 0 0", fif.fetch_req, fif.fetch_length, limit_do); end
      tick(); #1;
      n_tests++; if ({limit_do, pf_do} !== 2'b10) begin n_fail++; $display("FAIL t2_pulse got %b want 10", {limit_do, pf_do}); end
      tick(); #1;
      n_tests++; if ({limit_do, fif.fetch_req} !== 2'b00) begin n_fail++; $display("FAIL t2_after1 got %b want 00", {limit_do, fif.fetch_req}); end
      tick(); #1;
      n_tests++; if ({limit_do, fif.fetch_req} !== 2'b00) begin n_fail++; $display("FAIL t2_after2 got %b want 00", {limit_do, fif.fetch_req}); end
   endtask

   task automatic test_page_fault();
      restart(32'h2000, 32'h0000_FFFF);
      accept(); complete(1'b1); #1;
      n_tests++; if ({pf_do, limit_do, busy} !== 3'b100) begin n_fail++; $display("FAIL t3_pulse got %b want 100", {pf_do, limit_do, busy}); end
      n_tests++; if (fif.fetch_address !== 32'h2000) begin n_fail++; $display("FAIL t3_addr got %h want 00002000", fif.fetch_address); end
      tick(); #1;
      n_tests++; if ({pf_do, fif.fetch_req} !== 2'b00) begin n_fail++; $display("FAIL t3_after got %b want 00", {pf_do, fif.fetch_req}); end
   endtask

   task automatic test_throttle();
      used = 5'd12;
      restart(32'h4000, 32'h0000_FFFF); #1;
      n_tests++; if (fif.fetch_req !== 1'b0) begin n_fail++; $display("FAIL t4_used12 got %b want 0", fif.fetch_req); end
      tick(); used = 5'd11; #1;
      n_tests++; if ({fif.fetch_req, fif.fetch_address} !== {1'b1, 32'h4000}) begin n_fail++; $display("FAIL t4_used11 got %b %h want 1 00004000", fif.fetch_req, fif.fetch_address); end
      enable = 1'b0; #1;
      n_tests++; if (fif.fetch_req !== 1'b0) begin n_fail++; $display("FAIL t4_disabled got %b want 0", fif.fetch_req); end
      used = 5'd0;
      restart(32'h5010, 32'h500F);
      tick(); tick(); #1;
      n_tests++; if (limit_do !== 1'b0) begin n_fail++; $display("FAIL t4_lim_disabled got %b want 0", limit_do); end
      enable = 1'b1; used = 5'd16;
      tick(); tick(); #1;
      n_tests++; if (limit_do !== 1'b0) begin n_fail++; $display("FAIL t4_lim_full got %b want 0", limit_do); end
      used = 5'd0;
      tick(); #1;
      n_tests++; if (limit_do !== 1'b1) begin n_fail++; $display("FAIL t4_lim_pulse got %b want 1", limit_do); end
   endtask

   task automatic test_flush();
      restart(32'h1000, 32'h0000_FFFF);
      accept();
      start_addr = 32'h3000; pr_reset = 1'b1;
      tick(); pr_reset = 1'b0; #1;
      n_tests++; if ({busy, fif.fetch_req, fif.fetch_address} !== {2'b10, 32'h3000})
         begin n_fail++; $display("FAIL t5_drain got %b %b %h want 1 0 00003000", busy, fif.fetch_req, fif.fetch_address); end
      tick();
      complete(1'b1); #1;
      n_tests++; if ({pf_do, busy, fif.fetch_req, fif.fetch_address} !== {3'b001, 32'h3000})
         begin n_fail++; $display("FAIL t5_resume got %b %b %b %h want 0 0 1 00003000", pf_do, busy, fif.fetch_req, fif.fetch_address); end
      accept();
      start_addr = 32'h3100; pr_reset = 1'b1; fif.fetch_done = 1'b1; fif.fetch_page_fault = 1'b1;
      tick();
      pr_reset = 1'b0; fif.fetch_done = 1'b0; fif.fetch_page_fault = 1'b0; #1;
      n_tests++; if ({pf_do, busy, fif.fetch_req, fif.fetch_address} !== {3'b001, 32'h3100})
         begin n_fail++; $display("FAIL t5_coincide got %b %b %b %h want 0 0 1 00003100", pf_do, busy, fif.fetch_req, fif.fetch_address); end
   endtask

   task automatic test_wrap();
      restart(32'hFFFF_FFF8, 32'hFFFF_FFFF); #1;
      n_tests++; if ({fif.fetch_req, fif.fetch_address, fif.fetch_length} !== {1'b1, 32'hFFFF_FFF8, 5'd8})
         begin n_fail++; $display("FAIL t6_req0 got %b %h %0d want 1 fffffff8 8", fif.fetch_req, fif.fetch_address, fif.fetch_length); end
      accept(); complete(1'b0); #1;
      n_tests++; if ({fif.fetch_req, fif.fetch_address, fif.fetch_length} !== {1'b1, 32'h0, 5'd16})
         begin n_fail++; $display("FAIL t6_wrap got %b %h %0d want 1 00000000 16", fif.fetch_req, fif.fetch_address, fif.fetch_length); end
      accept(); rst_n = 1'b0;
      tick(); #1;
      n_tests++; if ({fif.fetch_req, fif.fetch_address, fif.fetch_length, limit_do, pf_do, busy} !== 41'd0)
         begin n_fail++; $display("FAIL t6_rst_wait got %b %h %0d %b%b%b want all 0", fif.fetch_req, fif.fetch_address, fif.fetch_length, limit_do, pf_do, busy); end
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_limit();
      test_page_fault();
      test_throttle();
      test_flush();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
